// File: rtl/tape_decoder.sv
// rtl/tape_decoder.sv - ZX81 tape pulse-train decoder recovering bytes from tape_in
//
// Ports:
//   clk         500 kHz system clock
//   rst_n       asynchronous active-low reset
//   tape_in     raw tape level, asynchronous to clk
//   enable      decoder armed; low clears the decoder to idle on the next cycle
//   byte_data   last assembled byte (held until the next byte)
//   byte_valid  one-cycle strobe: byte_data / byte_addr / first_byte valid
//   byte_addr   RAM address of the current byte, 0-based within the file
//   first_byte  high with byte_valid for the filename byte (byte_addr == 0)
//   bit_error   one-cycle strobe on a bit with an illegal pulse count
//   file_done   one-cycle strobe at end of file
//   file_len    number of bytes in the last completed file
//   busy        file reception in progress
`timescale 1ns/1ps
module tape_decoder #(
  parameter int MIN_HIGH   = 20,
  parameter int GAP_CYCLES = 150,
  parameter int EOF_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tape_in,
  input  logic        enable,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic [15:0] byte_addr,
  output logic        first_byte,
  output logic        bit_error,
  output logic        file_done,
  output logic [15:0] file_len,
  output logic        busy
);

  localparam logic [9:0]  MIN_H = 10'(MIN_HIGH);
  localparam logic [13:0] GAP_L = 14'(GAP_CYCLES);
  localparam logic [13:0] EOF_L = 14'(EOF_CYCLES);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t state, state_nxt;

  logic       sync1, sync2, level_d;
  logic       rise, fall;
  logic [9:0] hcnt;
  logic [13:0] lcnt;
  logic [4:0] pcnt;
  logic [2:0] bitcnt;
  logic [7:0] shreg;

  logic pulse_ok, bit_dec, eof_dec, bit_zero, bit_one;

  assign rise = sync2 & ~level_d;
  assign fall = ~sync2 & level_d;

  // A high shorter than MIN_H is a glitch: it neither counts nor restarts the gap.
  assign pulse_ok = (state == HIGH) && fall && (hcnt >= MIN_H);
  assign bit_dec  = (state == LOW) && (lcnt == GAP_L) && (pcnt != 5'd0);
  assign eof_dec  = (state == LOW) && (lcnt == EOF_L);
  assign bit_zero = (pcnt >= 5'd3) && (pcnt <= 5'd5);
  assign bit_one  = (pcnt >= 5'd7) && (pcnt <= 5'd11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = HIGH;
      HIGH:    if (fall) state_nxt = LOW;
      LOW: begin
        if (eof_dec)   state_nxt = IDLE;
        else if (rise) state_nxt = HIGH;
      end
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level_d    <= 1'b0;
      hcnt       <= '0;
      lcnt       <= '0;
      pcnt       <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      byte_addr  <= '0;
      first_byte <= 1'b0;
      bit_error  <= 1'b0;
      file_done  <= 1'b0;
      file_len   <= '0;
      busy       <= 1'b0;
    end else begin
      sync1      <= tape_in;
      sync2      <= sync1;
      level_d    <= sync2;
      byte_valid <= 1'b0;
      first_byte <= 1'b0;
      bit_error  <= 1'b0;
      file_done  <= 1'b0;
      if (!enable) begin
        hcnt      <= '0;
        lcnt      <= '0;
        pcnt      <= '0;
        bitcnt    <= '0;
        shreg     <= '0;
        byte_addr <= '0;
        busy      <= 1'b0;
      end else begin
        // Address advances the cycle after the strobe so the strobe carries the old value.
        if (byte_valid) byte_addr <= byte_addr + 16'd1;
        case (state)
          IDLE: if (rise) hcnt <= '0;
          HIGH: begin
            if (fall) begin
              if (pulse_ok) begin
                if (pcnt != 5'd31) pcnt <= pcnt + 5'd1;
                lcnt <= '0;
                busy <= 1'b1;
              end
            end else if (hcnt != 10'h3FF) begin
              hcnt <= hcnt + 10'd1;
            end
          end
          LOW: begin
            if (eof_dec) begin
              // Partial byte is dropped silently at end of file.
              lcnt   <= '0;
              pcnt   <= '0;
              bitcnt <= '0;
              shreg  <= '0;
              if (busy) begin
                file_done <= 1'b1;
                file_len  <= byte_addr;
                byte_addr <= '0;
                busy      <= 1'b0;
              end
            end else if (rise) begin
              hcnt <= '0;
            end else begin
              if (lcnt != 14'h3FFF) lcnt <= lcnt + 14'd1;
              if (bit_dec) begin
                pcnt <= '0;
                if (bit_zero || bit_one) begin
                  shreg <= {shreg[6:0], bit_one};
                  if (bitcnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shreg[6:0], bit_one};
                    first_byte <= (byte_addr == 16'd0);
                    bitcnt     <= '0;
                  end else begin
                    bitcnt <= bitcnt + 3'd1;
                  end
                end else begin
                  bit_error <= 1'b1;
                  shreg     <= '0;
                  bitcnt    <= '0;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tape_decoder.sv
// tb/tb_tape_decoder.sv - self-checking bench for tape_decoder with event scoreboard model
`timescale 1ns/1ps
module tb_tape_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tape_in;
  logic        enable;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [15:0] byte_addr;
  logic        first_byte;
  logic        bit_error;
  logic        file_done;
  logic [15:0] file_len;
  logic        busy;

  always #5 clk = ~clk;

  tape_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tape_in    (tape_in),
    .enable     (enable),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_addr  (byte_addr),
    .first_byte (first_byte),
    .bit_error  (bit_error),
    .file_done  (file_done),
    .file_len   (file_len),
    .busy       (busy)
  );

  localparam int EV_BYTE = 0;
  localparam int EV_ERR  = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int          kind;
    logic [7:0]  data;
    logic [15:0] addr;
  } ev_t;

  ev_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 1'b0;

  // Behavioural model: what the tape carries, in terms of bits/bytes/files.
  logic [7:0]  m_sr;
  int          m_bits;
  logic [15:0] m_addr;
  bit          m_busy;
  logic [7:0]  m_last_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] data, input logic [15:0] addr);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_sr = 8'h00;
    m_bits = 0;
    m_addr = 16'h0000;
    m_busy = 1'b0;
  endtask

  task automatic model_bit(input int p);
    logic b;
    if (p == 0) return;
    m_busy = 1'b1;
    if (p >= 3 && p <= 5)       b = 1'b0;
    else if (p >= 7 && p <= 11) b = 1'b1;
    else begin
      push_ev(EV_ERR, 8'h00, 16'h0000);
      m_sr = 8'h00;
      m_bits = 0;
      return;
    end
    m_sr = {m_sr[6:0], b};
    m_bits++;
    if (m_bits == 8) begin
      push_ev(EV_BYTE, m_sr, m_addr);
      m_last_byte = m_sr;
      m_addr = m_addr + 16'd1;
      m_bits = 0;
    end
  endtask

  task automatic model_eof();
    if (m_busy) push_ev(EV_DONE, 8'h00, m_addr);
    m_addr = 16'h0000;
    m_busy = 1'b0;
    m_bits = 0;
    m_sr = 8'h00;
  endtask

  task automatic model_disable();
    m_addr = 16'h0000;
    m_busy = 1'b0;
    m_bits = 0;
    m_sr = 8'h00;
  endtask

  task automatic drive(input logic lvl, input int n);
    tape_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  // glitch 1: 5-cycle high between the first two pulses; glitch 2: 10-cycle high in the gap.
  task automatic send_bit(input int p, input int hi, input int lo, input int gap, input int glitch);
    model_bit(p);
    for (int i = 0; i < p; i++) begin
      drive(1'b1, hi);
      if (i < p - 1) begin
        if (glitch == 1 && i == 0) begin
          drive(1'b0, 12);
          drive(1'b1, 5);
          drive(1'b0, 12);
        end else begin
          drive(1'b0, lo);
        end
      end
    end
    if (glitch == 2) begin
      drive(1'b0, 100);
      drive(1'b1, 10);
    end
    drive(1'b0, gap);
  endtask

  task automatic send_bit_r(input int p, input int glitch);
    send_bit(p, int'($urandom_range(32, 24)), int'($urandom_range(30, 20)),
             int'($urandom_range(200, 160)), glitch);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--)
      send_bit_r(b[i] ? int'($urandom_range(11, 7)) : int'($urandom_range(5, 3)), 0);
  endtask

  task automatic send_eof();
    model_eof();
    drive(1'b0, 9950);
  endtask

  ev_t cur;
  int  strobes;

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      strobes = int'(byte_valid) + int'(bit_error) + int'(file_done);
      if (first_byte && !byte_valid) check("first_without_valid", first_byte, 0);
      if (strobes != 0) begin
        check("strobe_overlap", strobes, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {byte_valid, bit_error, file_done}, 0);
        end else begin
          cur = exp_q.pop_front();
          case (cur.kind)
            EV_BYTE: begin
              check("kind_byte", byte_valid, 1);
              check("byte_data", byte_data, cur.data);
              check("byte_addr", byte_addr, cur.addr);
              check("first_byte", first_byte, cur.addr == 16'd0);
              check("busy_in_byte", busy, 1);
            end
            EV_ERR: check("kind_err", bit_error, 1);
            default: begin
              check("kind_done", file_done, 1);
              check("file_len", file_len, cur.addr);
              check("busy_after_done", busy, 0);
              check("addr_after_done", byte_addr, 0);
            end
          endcase
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    tape_in = 1'b0;
    enable = 1'b1;
    m_last_byte = 8'h00;
    model_reset();
    repeat (5) @(negedge clk);
    check("rst_byte_data", byte_data, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_addr", byte_addr, 0);
    check("rst_first_byte", first_byte, 0);
    check("rst_bit_error", bit_error, 0);
    check("rst_file_done", file_done, 0);
    check("rst_file_len", file_len, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    repeat (5) @(negedge clk);

    // File A: single byte 0x3F with fixed 4/9 pulse bursts.
    for (int i = 7; i >= 0; i--) send_bit((i >= 6) ? 4 : 9, 30, 30, 200, 0);
    send_eof();
    check("lit_file_len_A", file_len, 16'd1);
    check("lit_byte_data_A", byte_data, 8'h3F);
    check("lit_busy_A", busy, 0);

    // File B: multi-byte, bad bit mid-byte, glitches, random pulse counts.
    send_byte(8'hBF);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_bit_r(8, 0);
    send_bit_r(4, 0);
    send_bit_r(9, 0);
    send_bit_r(6, 0);
    send_byte(8'hC3);
    send_bit_r(4, 1);
    send_bit_r(4, 2);
    for (int i = 5; i >= 0; i--) send_bit_r((i == 5 || i == 0) ? 9 : 4, 0);
    for (int k = 0; k < 16; k++) send_bit_r(int'($urandom_range(13, 1)), 0);

    // Disarm for one cycle after five good bits.
    for (int k = 0; k < 5; k++) send_bit_r(int'($urandom_range(1, 0)) ? 9 : 4, 0);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    model_disable();
    check("dis_byte_addr", byte_addr, 0);
    check("dis_busy", busy, 0);
    check("dis_file_len_kept", file_len, 16'd1);
    check("dis_byte_data_kept", byte_data, m_last_byte);
    send_byte(8'h55);
    send_eof();
    check("lit_byte_data_55", byte_data, 8'h55);
    check("lit_file_len_55", file_len, 16'd1);

    // Asynchronous reset in the middle of a byte.
    for (int k = 0; k < 3; k++) send_bit_r(9, 0);
    drive(1'b1, 10);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_byte_data", byte_data, 0);
    check("arst_byte_addr", byte_addr, 0);
    check("arst_file_len", file_len, 0);
    check("arst_busy", busy, 0);
    check("arst_strobes", {byte_valid, first_byte, bit_error, file_done}, 0);
    model_reset();
    tape_in = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'hA5);
    drive(1'b0, 20);
    check("lit_byte_data_A5", byte_data, 8'hA5);
    check("lit_byte_addr_A5", byte_addr, 16'd1);
    check("lit_busy_A5", busy, 1);

    check("expected_events_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
